rf_up_interp_nx: RTL and testbench



---
 rtl/rf_up_interp_nx.sv | 192 +++++++++++++++++++
 tb/tb_rf_up_interp_nx.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_up_interp_nx.sv
// rf_up_interp_nx: 2x up-sampler, SPC_IN sc16 samples in, 2*SPC_IN out per cycle per channel.
// Modes: 0=zero-stuff, 1=sample-hold, 2=causal linear, 3=hold. Latency 2 cycles.
// Optional feature macro: RF_UP_INTERP_GAIN_EN adds per-channel Q2.14 gain (i_gain),
// saturating, with one extra pipeline stage (latency 3).
module rf_up_interp_nx #(
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned SPC_IN       = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         i_mode,
  input  logic                               i_clear,
  input  logic [NUM_CHANNELS*SPC_IN*32-1:0]  i_tdata,
  input  logic [NUM_CHANNELS-1:0]            i_tvalid,
`ifdef RF_UP_INTERP_GAIN_EN
  input  logic [NUM_CHANNELS*16-1:0]         i_gain,
`endif
  output logic [NUM_CHANNELS*SPC_IN*64-1:0]  o_tdata,
  output logic [NUM_CHANNELS-1:0]            o_tvalid
);

  localparam int unsigned IW = SPC_IN * 32;
  localparam int unsigned OW = SPC_IN * 64;

  localparam logic [1:0] ModeZero   = 2'd0;
  localparam logic [1:0] ModeHold   = 2'd1;
  localparam logic [1:0] ModeLinear = 2'd2;

  // (a+b+1)>>>1 on a sign-extended 17-bit sum; result always fits in 16 bits.
  function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b} + 17'd1;
    return s[16:1];
  endfunction

`ifdef RF_UP_INTERP_GAIN_EN
  // Q2.14 multiply, round half-up, saturate to 16 bits.
  function automatic logic [15:0] scale16(input logic [15:0] v, input logic [15:0] g);
    logic signed [32:0] p;
    p = ($signed(v) * $signed(g)) + 33'sd8192;
    p = p >>> 14;
    if (p > 33'sd32767) begin
      return 16'h7fff;
    end else if (p < -33'sd32768) begin
      return 16'h8000;
    end
    return p[15:0];
  endfunction
`endif

  logic r_s1_clear;

  // History clear travels with stage 1 so it lands after any beat accepted with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_clear <= 1'b0;
    end else begin
      r_s1_clear <= i_clear;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [IW-1:0] r_s1_data;
    logic          r_s1_valid;
    logic [1:0]    r_s1_mode;
    logic [31:0]   r_h;
    logic          r_hv;
    logic [1:0]    r_last_mode;
    logic [OW-1:0] r_s2_data;
    logic          r_s2_valid;
    logic [OW-1:0] w_interp;
    logic [31:0]   w_x;
    logic [31:0]   w_prev;

    // Stage 1: capture the beat and its mode; mode only moves on a valid beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_s1_data  <= '0;
        r_s1_mode  <= ModeHold;
      end else begin
        r_s1_valid <= i_tvalid[c];
        if (i_tvalid[c]) begin
          r_s1_data <= i_tdata[c*IW +: IW];
          r_s1_mode <= i_mode;
        end
      end
    end

    // Interpolate the stage-1 beat; x[-1] is history only if the previous beat was linear.
    always_comb begin
      w_interp = '0;
      w_x      = '0;
      w_prev   = (r_hv && (r_last_mode == ModeLinear)) ? r_h : r_s1_data[31:0];
      for (int k = 0; k < SPC_IN; k++) begin
        w_x = r_s1_data[k*32 +: 32];
        case (r_s1_mode)
          ModeZero: begin
            w_interp[2*k*32 +: 32]     = w_x;
            w_interp[(2*k+1)*32 +: 32] = '0;
          end
          ModeLinear: begin
            w_interp[2*k*32 +: 32]     = {avg16(w_prev[31:16], w_x[31:16]),
                                          avg16(w_prev[15:0], w_x[15:0])};
            w_interp[(2*k+1)*32 +: 32] = w_x;
          end
          default: begin
            w_interp[2*k*32 +: 32]     = w_x;
            w_interp[(2*k+1)*32 +: 32] = w_x;
          end
        endcase
        w_prev = w_x;
      end
    end

    // Stage 2: register outputs and update history; a clear overrides the beat's update.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_valid  <= 1'b0;
        r_s2_data   <= '0;
        r_h         <= '0;
        r_hv        <= 1'b0;
        r_last_mode <= ModeHold;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data   <= w_interp;
          r_last_mode <= r_s1_mode;
        end
        if (r_s1_clear) begin
          r_h  <= '0;
          r_hv <= 1'b0;
        end else if (r_s1_valid) begin
          r_h  <= r_s1_data[IW-1 -: 32];
          r_hv <= 1'b1;
        end
      end
    end

`ifdef RF_UP_INTERP_GAIN_EN
    logic [15:0]   r_s1_gain;
    logic [15:0]   r_s2_gain;
    logic [OW-1:0] r_s3_data;
    logic          r_s3_valid;
    logic [OW-1:0] w_scaled;

    // Gain rides along with the beat through stages 1 and 2.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_gain <= '0;
        r_s2_gain <= '0;
      end else begin
        if (i_tvalid[c]) begin
          r_s1_gain <= i_gain[c*16 +: 16];
        end
        if (r_s1_valid) begin
          r_s2_gain <= r_s1_gain;
        end
      end
    end

    // Apply gain to every I and Q of the interpolated beat.
    always_comb begin
      w_scaled = '0;
      for (int j = 0; j < 2*SPC_IN; j++) begin
        w_scaled[j*32+16 +: 16] = scale16(r_s2_data[j*32+16 +: 16], r_s2_gain);
        w_scaled[j*32 +: 16]    = scale16(r_s2_data[j*32 +: 16], r_s2_gain);
      end
    end

    // Stage 3: register scaled outputs; data holds while invalid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s3_valid <= 1'b0;
        r_s3_data  <= '0;
      end else begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_s3_data <= w_scaled;
        end
      end
    end

    assign o_tdata[c*OW +: OW] = r_s3_data;
    assign o_tvalid[c]         = r_s3_valid;
`else
    assign o_tdata[c*OW +: OW] = r_s2_data;
    assign o_tvalid[c]         = r_s2_valid;
`endif
  end

endmodule

// File: tb/tb_rf_up_interp_nx.sv
// Testbench for rf_up_interp_nx: directed cases plus randomized streams vs a reference model.
// Build with RF_UP_INTERP_GAIN_EN defined to exercise the gain stage.
module tb_rf_up_interp_nx;
  localparam int NCH = 2;
  localparam int SPC = 2;
  localparam int IW  = SPC * 32;
  localparam int OW  = SPC * 64;
`ifdef RF_UP_INTERP_GAIN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         i_mode;
  logic               i_clear;
  logic [NCH*IW-1:0]  i_tdata;
  logic [NCH-1:0]     i_tvalid;
  logic [NCH*16-1:0]  i_gain;
  logic [NCH*OW-1:0]  o_tdata;
  logic [NCH-1:0]     o_tvalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_up_interp_nx #(
    .NUM_CHANNELS(NCH),
    .SPC_IN      (SPC)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_mode  (i_mode),
    .i_clear (i_clear),
    .i_tdata (i_tdata),
    .i_tvalid(i_tvalid),
`ifdef RF_UP_INTERP_GAIN_EN
    .i_gain  (i_gain),
`endif
    .o_tdata (o_tdata),
    .o_tvalid(o_tvalid)
  );

  // Reference model state: history sample, history-valid, previous beat was linear.
  logic [31:0]    m_h   [NCH];
  bit             m_hv  [NCH];
  bit             m_lin [NCH];
  // Expected-output delay line and last expected data per channel.
  logic [NCH-1:0] ev_pipe [LAT];
  logic [OW-1:0]  ed_pipe [NCH][LAT];
  logic [OW-1:0]  e_hold  [NCH];

  function automatic int gain_apply(int v, logic [15:0] g);
    int p;
    p = v * int'($signed(g));
    p = (p + 8192) >>> 14;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p;
  endfunction

  function automatic logic [OW-1:0] model_beat(int ch, logic [1:0] mode, logic [IW-1:0] x,
                                               logic [15:0] g);
    int xi [SPC+1];
    int xq [SPC+1];
    int yi [2*SPC];
    int yq [2*SPC];
    logic [OW-1:0] y;
    y = '0;
    if (mode == 2'd2 && !m_lin[ch]) m_hv[ch] = 1'b0;
    for (int k = 0; k < SPC; k++) begin
      xi[k+1] = int'($signed(x[k*32+16 +: 16]));
      xq[k+1] = int'($signed(x[k*32 +: 16]));
    end
    xi[0] = m_hv[ch] ? int'($signed(m_h[ch][31:16])) : xi[1];
    xq[0] = m_hv[ch] ? int'($signed(m_h[ch][15:0])) : xq[1];
    for (int k = 0; k < SPC; k++) begin
      case (mode)
        2'd0: begin
          yi[2*k] = xi[k+1]; yi[2*k+1] = 0;
          yq[2*k] = xq[k+1]; yq[2*k+1] = 0;
        end
        2'd2: begin
          yi[2*k] = (xi[k] + xi[k+1] + 1) >>> 1; yi[2*k+1] = xi[k+1];
          yq[2*k] = (xq[k] + xq[k+1] + 1) >>> 1; yq[2*k+1] = xq[k+1];
        end
        default: begin
          yi[2*k] = xi[k+1]; yi[2*k+1] = xi[k+1];
          yq[2*k] = xq[k+1]; yq[2*k+1] = xq[k+1];
        end
      endcase
    end
    for (int j = 0; j < 2*SPC; j++) begin
`ifdef RF_UP_INTERP_GAIN_EN
      yi[j] = gain_apply(yi[j], g);
      yq[j] = gain_apply(yq[j], g);
`endif
      y[j*32+16 +: 16] = 16'(yi[j]);
      y[j*32 +: 16]    = 16'(yq[j]);
    end
    m_h[ch]   = x[IW-1 -: 32];
    m_hv[ch]  = 1'b1;
    m_lin[ch] = (mode == 2'd2);
    return y;
  endfunction

  // Feed current inputs to the model, then advance one clock and settle.
  task automatic tick();
    logic [OW-1:0] nd [NCH];
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_h[ch] = '0; m_hv[ch] = 1'b0; m_lin[ch] = 1'b0; e_hold[ch] = '0;
        for (int i = 0; i < LAT; i++) ed_pipe[ch][i] = '0;
      end
      for (int i = 0; i < LAT; i++) ev_pipe[i] = '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        nd[ch] = '0;
        if (i_tvalid[ch]) nd[ch] = model_beat(ch, i_mode, i_tdata[ch*IW +: IW],
                                              i_gain[ch*16 +: 16]);
      end
      if (i_clear) begin
        for (int ch = 0; ch < NCH; ch++) begin
          m_h[ch] = '0; m_hv[ch] = 1'b0;
        end
      end
      for (int i = LAT-1; i > 0; i--) begin
        ev_pipe[i] = ev_pipe[i-1];
        for (int ch = 0; ch < NCH; ch++) ed_pipe[ch][i] = ed_pipe[ch][i-1];
      end
      ev_pipe[0] = i_tvalid;
      for (int ch = 0; ch < NCH; ch++) begin
        ed_pipe[ch][0] = nd[ch];
        if (ev_pipe[LAT-1][ch]) e_hold[ch] = ed_pipe[ch][LAT-1];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_tvalid = '0; i_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_beat(int ch, logic [1:0] mode, logic [IW-1:0] x);
    i_tvalid = '0;
    i_tvalid[ch] = 1'b1;
    i_tdata[ch*IW +: IW] = x;
    i_mode = mode;
  endtask

  // Single beat on channel 0, then idle until its output is due.
  task automatic run_beat(logic [1:0] mode, logic [IW-1:0] x, logic clr);
    set_beat(0, mode, x);
    i_clear = clr;
    tick();
    i_tvalid = '0;
    i_clear = 1'b0;
    repeat (LAT-1) tick();
  endtask

  function automatic logic [IW-1:0] in_i(int a, int b);
    return {16'(b), 16'h0, 16'(a), 16'h0};
  endfunction

  function automatic logic [OW-1:0] out_i(int a, int b, int c, int d);
    return {16'(d), 16'h0, 16'(c), 16'h0, 16'(b), 16'h0, 16'(a), 16'h0};
  endfunction

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (o_tvalid !== '0 || o_tdata !== '0) begin
        n_fail++;
        $display("FAIL reset: o_tvalid=%b o_tdata=%h, expected 0/0", o_tvalid, o_tdata);
      end
      tick();
    end
  endtask

  task automatic test_hold_zero();
    logic [OW-1:0] exp_h;
    logic [OW-1:0] exp_z;
    exp_h = {32'h00030004, 32'h00030004, 32'h00010002, 32'h00010002};
    exp_z = {32'h0, 32'h00030004, 32'h0, 32'h00010002};
    set_beat(0, 2'd1, {32'h00030004, 32'h00010002});
    tick();
    i_tvalid = '0;
    n_checks++;
    if (o_tvalid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_latency_early: o_tvalid=%b, expected 0", o_tvalid[0]);
    end
    repeat (LAT-1) tick();
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== exp_h) begin
      n_fail++;
      $display("FAIL hold: o_tvalid=%b o_tdata=%h, expected 1/%h", o_tvalid[0],
               o_tdata[OW-1:0], exp_h);
    end
    tick();
    n_checks++;
    if (o_tvalid[0] !== 1'b0 || o_tdata[OW-1:0] !== exp_h) begin
      n_fail++;
      $display("FAIL hold_idle_keep: o_tvalid=%b o_tdata=%h, expected 0/%h", o_tvalid[0],
               o_tdata[OW-1:0], exp_h);
    end
    run_beat(2'd0, {32'h00030004, 32'h00010002}, 1'b0);
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== exp_z) begin
      n_fail++;
      $display("FAIL zero: o_tvalid=%b o_tdata=%h, expected 1/%h", o_tvalid[0],
               o_tdata[OW-1:0], exp_z);
    end
  endtask

  task automatic test_linear();
    // Back-to-back beats.
    do_reset();
    set_beat(0, 2'd2, in_i(10, 20));
    tick();
    set_beat(0, 2'd2, in_i(30, -40));
    tick();
    i_tvalid = '0;
    repeat (LAT-2) tick();
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== out_i(10, 10, 15, 20)) begin
      n_fail++;
      $display("FAIL linear_b1: got %b/%h, expected 1/%h", o_tvalid[0], o_tdata[OW-1:0],
               out_i(10, 10, 15, 20));
    end
    tick();
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== out_i(25, 30, -5, -40)) begin
      n_fail++;
      $display("FAIL linear_b2: got %b/%h, expected 1/%h", o_tvalid[0], o_tdata[OW-1:0],
               out_i(25, 30, -5, -40));
    end
    // Same beats with a 5-cycle gap; mode input toggles while idle.
    do_reset();
    run_beat(2'd2, in_i(10, 20), 1'b0);
    n_checks++;
    if (o_tdata[OW-1:0] !== out_i(10, 10, 15, 20)) begin
      n_fail++;
      $display("FAIL linear_gap_b1: got %h, expected %h", o_tdata[OW-1:0], out_i(10, 10, 15, 20));
    end
    i_mode = 2'd0;
    repeat (5) tick();
    run_beat(2'd2, in_i(30, -40), 1'b0);
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== out_i(25, 30, -5, -40)) begin
      n_fail++;
      $display("FAIL linear_gap_b2: got %b/%h, expected 1/%h", o_tvalid[0], o_tdata[OW-1:0],
               out_i(25, 30, -5, -40));
    end
  endtask

  task automatic test_avg_extremes();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [15:0] tr [3];
    logic [OW-1:0] exp;
    ta = '{16'h7fff, 16'h8000, 16'hfffd};
    tb = '{16'h7fff, 16'h7fff, 16'h0000};
    tr = '{16'h7fff, 16'h0000, 16'hffff};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      run_beat(2'd2, {tb[t], tb[t], ta[t], ta[t]}, 1'b0);
      exp = {tb[t], tb[t], tr[t], tr[t], ta[t], ta[t], ta[t], ta[t]};
      n_checks++;
      if (o_tdata[OW-1:0] !== exp) begin
        n_fail++;
        $display("FAIL avg_extreme_%0d: got %h, expected %h", t, o_tdata[OW-1:0], exp);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    run_beat(2'd2, in_i(10, 20), 1'b0);
    run_beat(2'd2, in_i(30, -40), 1'b1);
    n_checks++;
    if (o_tdata[OW-1:0] !== out_i(25, 30, -5, -40)) begin
      n_fail++;
      $display("FAIL clear_b2: got %h, expected %h", o_tdata[OW-1:0], out_i(25, 30, -5, -40));
    end
    run_beat(2'd2, in_i(2, 4), 1'b0);
    n_checks++;
    if (o_tdata[OW-1:0] !== out_i(2, 2, 3, 4)) begin
      n_fail++;
      $display("FAIL clear_b3: got %h, expected %h", o_tdata[OW-1:0], out_i(2, 2, 3, 4));
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    run_beat(2'd2, in_i(10, 20), 1'b0);
    set_beat(0, 2'd2, in_i(30, -40));
    i_tvalid[1] = 1'b1;
    i_tdata[IW +: IW] = in_i(7, 9);
    tick();
    set_beat(0, 2'd2, in_i(50, 60));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_tvalid = '0;
    for (int c = 0; c <= LAT; c++) begin
      n_checks++;
      if (o_tvalid !== '0 || o_tdata !== '0) begin
        n_fail++;
        $display("FAIL reset_inflight_%0d: o_tvalid=%b o_tdata=%h, expected 0/0", c, o_tvalid,
                 o_tdata);
      end
      tick();
    end
    run_beat(2'd2, in_i(2, 4), 1'b0);
    n_checks++;
    if (o_tvalid[0] !== 1'b1 || o_tdata[OW-1:0] !== out_i(2, 2, 3, 4)) begin
      n_fail++;
      $display("FAIL reset_first_beat: got %b/%h, expected 1/%h", o_tvalid[0], o_tdata[OW-1:0],
               out_i(2, 2, 3, 4));
    end
  endtask

`ifdef RF_UP_INTERP_GAIN_EN
  task automatic test_gain();
    logic [OW-1:0] exp0;
    logic [OW-1:0] exp1;
    do_reset();
    exp0 = {4{32'h80008000}};
    exp1 = {4{32'h7fff8000}};
    i_gain = {16'h4000, 16'h8000};
    i_mode = 2'd1;
    i_tvalid = 2'b11;
    i_tdata = {32'h7fff8000, 32'h7fff8000, 32'h40004000, 32'h40004000};
    tick();
    i_tvalid = '0;
    i_gain = {NCH{16'h4000}};
    repeat (LAT-1) tick();
    n_checks++;
    if (o_tvalid !== 2'b11 || o_tdata[OW-1:0] !== exp0 || o_tdata[2*OW-1:OW] !== exp1) begin
      n_fail++;
      $display("FAIL gain_sat: got %b/%h, expected 11/%h%h", o_tvalid, o_tdata, exp1, exp0);
    end
  endtask
`endif

  // Drive one random cycle of stimulus on all inputs.
  task automatic rand_inputs(logic [NCH-1:0] valid);
    logic [31:0] ext [4];
    ext = '{32'h7fff8000, 32'h80007fff, 32'h7fff7fff, 32'h80008000};
    i_tvalid = valid;
    if ($urandom_range(0, 7) == 0) i_mode = 2'($urandom_range(0, 3));
    i_clear = ($urandom_range(0, 15) == 0);
    for (int j = 0; j < NCH*SPC; j++) begin
      if ($urandom_range(0, 3) == 0) i_tdata[j*32 +: 32] = ext[$urandom_range(0, 3)];
      else i_tdata[j*32 +: 32] = $urandom;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if ($urandom_range(0, 3) == 0) i_gain[ch*16 +: 16] = 16'($urandom);
      else i_gain[ch*16 +: 16] = 16'h4000;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_inputs(NCH'($urandom));
      tick();
      for (int ch = 0; ch < NCH; ch++) begin
        n_checks++;
        if (o_tvalid[ch] !== ev_pipe[LAT-1][ch] || o_tdata[ch*OW +: OW] !== e_hold[ch]) begin
          n_fail++;
          $display("FAIL random c%0d ch%0d: got %b/%h, expected %b/%h", c, ch, o_tvalid[ch],
                   o_tdata[ch*OW +: OW], ev_pipe[LAT-1][ch], e_hold[ch]);
        end
      end
    end
    i_tvalid = '0;
    i_clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_mode = 2'd2;
    for (int c = 0; c < 60; c++) begin
      rand_inputs('1);
      tick();
      for (int ch = 0; ch < NCH; ch++) begin
        n_checks++;
        if (o_tvalid[ch] !== ev_pipe[LAT-1][ch] || o_tdata[ch*OW +: OW] !== e_hold[ch]) begin
          n_fail++;
          $display("FAIL b2b c%0d ch%0d: got %b/%h, expected %b/%h", c, ch, o_tvalid[ch],
                   o_tdata[ch*OW +: OW], ev_pipe[LAT-1][ch], e_hold[ch]);
        end
      end
    end
    i_tvalid = '0;
    i_clear = 1'b0;
    i_gain = {NCH{16'h4000}};
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_mode = 2'd1;
    i_clear = 1'b0;
    i_tdata = '0;
    i_tvalid = '0;
    i_gain = {NCH{16'h4000}};
    test_reset();
    test_hold_zero();
    test_linear();
    test_avg_extremes();
    test_clear();
    test_reset_midstream();
`ifdef RF_UP_INTERP_GAIN_EN
    test_gain();
`endif
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
